// File: rtl/div_pkg.sv
// Shared definitions for the multicycle divider: operation encodings
// (funct3[1:0]), FSM state encodings and small op-decode helpers.
// No ports.
package div_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // op[0]=0 selects the signed variants (DIV, REM)
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // op[1]=1 selects the remainder variants (REM, REMU)
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit_mc_if.sv
// Request/response bundle between the core's operand registers and the
// divider.
//   valid     start request (master -> slave)
//   op        funct3[1:0] operation select
//   dividend  rs1 value
//   divisor   rs2 value
//   result    quotient or remainder (slave -> master)
//   ready     one-cycle completion pulse
//   busy      divider occupied
interface div_unit_mc_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] result;
  logic             ready;
  logic             busy;

  modport master (
    output valid, op, dividend, divisor,
    input  result, ready, busy
  );

  modport slave (
    input  valid, op, dividend, divisor,
    output result, ready, busy
  );
endinterface

// File: rtl/div_step.sv
// One combinational radix-2 restoring iteration.
//   i_rem      partial remainder (always < divisor)
//   i_quo      quotient register; its MSB is the next dividend bit shifted in
//   i_divisor  unsigned divisor magnitude
//   o_rem      next partial remainder
//   o_quo      next quotient register (new quotient bit in LSB)
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_divisor};

  // Borrow (MSB set) means the trial subtraction failed: restore.
  assign o_rem = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_diff[WIDTH]};
endmodule

// File: rtl/div_unit_mc.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU) for the multicycle core.
// Fixed latency: accept edge, WIDTH CALC cycles, one DONE cycle with ready.
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    slave side of div_unit_mc_if (valid/op/dividend/divisor in,
//          result/ready/busy out)
//
// state  | meaning
// S_IDLE | waiting for valid; operands latched on accept
// S_CALC | one restoring step per cycle, WIDTH steps
// S_DONE | result registered, ready high for this cycle
module div_unit_mc
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  div_unit_mc_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvsr, r_dvnd, r_result;
  logic             r_neg_q, r_neg_r, r_div_zero, r_is_rem;
  logic             r_ready, r_busy;

  logic             w_signed;
  logic [WIDTH-1:0] w_abs_dvnd, w_abs_dvsr;
  logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt;
  logic [WIDTH-1:0] w_quo_fix, w_rem_fix, w_sel;

  assign w_signed   = op_is_signed(bus.op);
  // Magnitude of -2^(WIDTH-1) wraps to itself, which is the correct unsigned value.
  assign w_abs_dvnd = (w_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign w_abs_dvsr = (w_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_dvsr),
    .o_rem     (w_rem_nxt),
    .o_quo     (w_quo_nxt)
  );

  // Output fix-up works on the last step's outputs so result is loaded on
  // the edge that enters DONE.
  always_comb begin
    w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    if (r_div_zero) begin
      w_sel = r_is_rem ? r_dvnd : '1;
    end else begin
      w_sel = r_is_rem ? w_rem_fix : w_quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvsr     <= '0;
      r_dvnd     <= '0;
      r_result   <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_is_rem   <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.valid) begin
            r_rem      <= '0;
            r_quo      <= w_abs_dvnd;  // dividend bits shift out of the quotient MSB
            r_dvsr     <= w_abs_dvsr;
            r_dvnd     <= bus.dividend;
            r_neg_q    <= w_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            r_neg_r    <= w_signed & bus.dividend[WIDTH-1];
            r_div_zero <= (bus.divisor == '0);
            r_is_rem   <= op_is_rem(bus.op);
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (r_cnt == LAST) begin
            r_result <= w_sel;
            r_ready  <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.ready  = r_ready;
  assign bus.busy   = r_busy;
endmodule

// File: tb/tb_div_unit_mc.sv
module tb_div_unit_mc;
  import div_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;
  localparam int WIN = LAT + 7;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  div_unit_mc_if #(.WIDTH(W)) bus ();

  div_unit_mc #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RISC-V division semantics from plain integer arithmetic.
  function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 0) return op[1] ? a : {W{1'b1}};
    if (op[0] == 1'b0) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return op[1] ? rv[W-1:0] : qv[W-1:0];
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corners [6];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    corners[5] = 32'hFFFF_FFFE;
    case ($urandom_range(0, 3))
      0:       return corners[$urandom_range(0, 5)];
      1:       return W'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request and watch a bounded window after the accept edge.
  // Cycle k is observed at the k-th falling edge after acceptance.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int lat, output int nrdy,
                        output int busy_err);
    @(negedge clk);
    bus.valid    = 1'b1;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.valid    = 1'b0;
    bus.op       = 2'($urandom);
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    res      = 'x;
    lat      = -1;
    nrdy     = 0;
    busy_err = 0;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        nrdy++;
        if (lat < 0) begin
          lat = k;
          res = bus.result;
        end
      end
      if (bus.busy !== (k <= LAT)) busy_err++;
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.valid    = 1'b0;
    bus.op       = 2'b00;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.result !== '0 || bus.ready !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: result=%h ready=%b busy=%b required 0/0/0",
               bus.result, bus.ready, bus.busy);
    end
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  task automatic test_directed();
    vec_t v [12];
    logic [W-1:0] res;
    int lat, nrdy, berr;
    v[0]  = '{DIV_OP_DIVU, 32'd100,        32'd7,          32'd14};
    v[1]  = '{DIV_OP_REMU, 32'd100,        32'd7,          32'd2};
    v[2]  = '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    v[3]  = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    v[4]  = '{DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1};
    v[5]  = '{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    v[6]  = '{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    v[7]  = '{DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF};
    v[8]  = '{DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF};
    v[9]  = '{DIV_OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
    v[10] = '{DIV_OP_REMU, 32'd9,          32'd0,          32'd9};
    v[11] = '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, res, lat, nrdy, berr);
      checks++;
      if (res !== v[i].exp) begin
        failures++;
        $display("FAIL directed_result[%0d]: op=%0d a=%h b=%h got=%h required=%h",
                 i, v[i].op, v[i].a, v[i].b, res, v[i].exp);
      end
      checks++;
      if (lat !== LAT || nrdy !== 1) begin
        failures++;
        $display("FAIL directed_latency[%0d]: ready_cycle=%0d pulses=%0d required %0d/1",
                 i, lat, nrdy, LAT);
      end
      checks++;
      if (berr !== 0) begin
        failures++;
        $display("FAIL directed_busy[%0d]: %0d cycles wrong, required busy for cycles 1..%0d",
                 i, berr, LAT);
      end
    end
    // result must hold after ready drops
    checks++;
    if (bus.result !== v[11].exp) begin
      failures++;
      $display("FAIL result_hold: got=%h required=%h", bus.result, v[11].exp);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, res, exp;
    logic [1:0] op;
    int lat, nrdy, berr;
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom);
      a   = pick_operand();
      b   = pick_operand();
      exp = ref_div(op, a, b);
      run_op(op, a, b, res, lat, nrdy, berr);
      checks++;
      if (res !== exp || lat !== LAT || nrdy !== 1 || berr !== 0) begin
        failures++;
        $display("FAIL random[%0d]: op=%0d a=%h b=%h got=%h lat=%0d pulses=%0d busy_err=%0d required=%h lat=%0d",
                 i, op, a, b, res, lat, nrdy, berr, exp, LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res, a, b;
    int lat, nrdy, berr, busy_late;
    @(negedge clk);
    bus.valid    = 1'b1;
    bus.op       = DIV_OP_DIVU;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    lat = -1; nrdy = 0; busy_late = 0; res = 'x;
    for (int k = 1; k <= WIN + 10; k++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        nrdy++;
        if (lat < 0) begin
          lat = k;
          res = bus.result;
        end
      end
      if (k > LAT && bus.busy !== 1'b0) busy_late++;
      // valid stays high through CALC and the DONE cycle, dropped before IDLE
      if (k < LAT) begin
        bus.dividend = $urandom;
        bus.divisor  = $urandom | 32'd1;
        bus.op       = 2'($urandom);
      end else begin
        bus.valid = 1'b0;
      end
    end
    checks++;
    if (nrdy !== 1 || lat !== LAT) begin
      failures++;
      $display("FAIL held_valid_pulses: pulses=%0d ready_cycle=%0d required 1/%0d", nrdy, lat, LAT);
    end
    checks++;
    if (res !== 32'd333) begin
      failures++;
      $display("FAIL held_valid_result: got=%h required=%h", res, 32'd333);
    end
    checks++;
    if (busy_late !== 0) begin
      failures++;
      $display("FAIL held_valid_no_restart: busy high %0d cycles after DONE, required 0", busy_late);
    end
    a = $urandom;
    b = W'($urandom_range(1, 1000));
    run_op(DIV_OP_DIVU, a, b, res, lat, nrdy, berr);
    checks++;
    if (res !== a / b || lat !== LAT || nrdy !== 1 || berr !== 0) begin
      failures++;
      $display("FAIL fresh_after_held: got=%h lat=%0d pulses=%0d required=%h lat=%0d",
               res, lat, nrdy, a / b, LAT);
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] res;
    int lat, nrdy, berr, rdy_seen;
    @(negedge clk);
    bus.valid    = 1'b1;
    bus.op       = DIV_OP_DIVU;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    rdy_seen  = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) rdy_seen++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.result !== '0) begin
      failures++;
      $display("FAIL abort_state: busy=%b result=%h required 0/0", bus.busy, bus.result);
    end
    for (int k = 0; k < WIN; k++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) rdy_seen++;
    end
    checks++;
    if (rdy_seen !== 0 || bus.result !== '0) begin
      failures++;
      $display("FAIL abort_no_ready: pulses=%0d result=%h required 0/0", rdy_seen, bus.result);
    end
    run_op(DIV_OP_DIVU, 32'd50, 32'd5, res, lat, nrdy, berr);
    checks++;
    if (res !== 32'd10 || lat !== LAT || nrdy !== 1 || berr !== 0) begin
      failures++;
      $display("FAIL after_abort: got=%h lat=%0d pulses=%0d required=%h lat=%0d",
               res, lat, nrdy, 32'd10, LAT);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
